// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared types and helpers for the mux-based serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    // Serializer control states: waiting for a word, or streaming its bits
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } serializer_state_t;

    // Width of the beat counter for a given word width
    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================================
// Module      : mux
// Description : 2:1 single-bit multiplexer primitive (i_sel=1 picks i_d1).
// Revision    : 1.0 - initial release
// ============================================================================
module mux (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule
`default_nettype wire

// File: rtl/serializer_using_mux.sv
`default_nettype none
// ============================================================================
// Module      : serializer_using_mux
// Description : Parallel-to-serial converter. Accepts a WIDTH-bit word over a
//               valid/ready handshake and emits it one bit per beat on a
//               1-bit valid/ready stream. Each shift-register bit's next value
//               comes from a 2:1 mux (load vs. shift); hold is a clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
module serializer_using_mux
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             down_valid,
    output logic             down_data,
    output logic             down_last,
    input  logic             down_ready
);

    localparam int                 c_CNT_W    = CNT_W(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam int                 c_OUT_IDX  = MSB_FIRST ? (WIDTH - 1) : 0;

    serializer_state_t  r_state;
    serializer_state_t  w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shift_src;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_load;
    logic               w_beat;
    logic               w_last;
    logic               w_shreg_en;

    assign w_last = (r_cnt == c_CNT_LAST);

    // The final beat leaves the register untouched; its contents no longer
    // matter once the state returns to IDLE.
    assign w_shreg_en = w_load | (w_beat & ~w_last);

    // Outputs are decoded from registered state only, so neither up_valid nor
    // down_ready has a combinational path to any output.
    assign down_data = (r_state == SHIFT) & r_shreg[c_OUT_IDX];
    assign down_last = (r_state == SHIFT) & w_last;

    // Per-bit shift source plus load/shift mux; the fill end shifts in zero
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (MSB_FIRST) begin : g_msb
            if (i == 0) begin : g_fill
                assign w_shift_src[i] = 1'b0;
            end else begin : g_nbr
                assign w_shift_src[i] = r_shreg[i-1];
            end
        end else begin : g_lsb
            if (i == WIDTH - 1) begin : g_fill
                assign w_shift_src[i] = 1'b0;
            end else begin : g_nbr
                assign w_shift_src[i] = r_shreg[i+1];
            end
        end

        mux u_mux (
            .i_d0  (w_shift_src[i]),
            .i_d1  (up_data[i]),
            .i_sel (w_load),
            .o_y   (w_shreg_nxt[i])
        );
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        up_ready    = 1'b0;
        down_valid  = 1'b0;
        w_load      = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                down_valid = 1'b1;
                if (down_ready) begin
                    w_beat = 1'b1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register: loads a new word or shifts one place per beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (w_shreg_en) begin
            r_shreg <= w_shreg_nxt;
        end
    end

    // Beat counter: cleared on load, stops at the last beat instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_beat && !w_last) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serializer_using_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializer_using_mux
// Description : Self-checking bench for serializer_using_mux (LSB- and
//               MSB-first instances driven in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializer_using_mux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         up_valid = 1'b0;
    logic [W-1:0] up_data = '0;
    logic         down_ready = 1'b0;

    logic l_up_ready, l_dv, l_dd, l_dl;
    logic m_up_ready, m_dv, m_dd, m_dl;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a word is simply the list of bits still to be sent
    bit q_l[$];
    bit q_m[$];

    bit exp_c1_l[8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    bit exp_c1_m[8] = '{1, 1, 0, 0, 0, 0, 0, 1};
    bit exp_01_l[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit exp_01_m[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    serializer_using_mux #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (l_up_ready),
        .down_valid (l_dv),
        .down_data  (l_dd),
        .down_last  (l_dl),
        .down_ready (down_ready)
    );

    serializer_using_mux #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (m_up_ready),
        .down_valid (m_dv),
        .down_data  (m_dd),
        .down_last  (m_dl),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    endtask

    // Model update: pop a bit on an accepted beat, push a whole word when empty
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_l.delete();
            q_m.delete();
        end else begin
            if (q_l.size() != 0 && down_ready) void'(q_l.pop_front());
            else if (q_l.size() == 0 && up_valid)
                for (int i = 0; i < W; i++) q_l.push_back(up_data[i]);
            if (q_m.size() != 0 && down_ready) void'(q_m.pop_front());
            else if (q_m.size() == 0 && up_valid)
                for (int i = 0; i < W; i++) q_m.push_back(up_data[W-1-i]);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("lsb_up_ready", l_up_ready, q_l.size() == 0);
        check("lsb_down_valid", l_dv, q_l.size() != 0);
        check("lsb_down_last", l_dl, q_l.size() == 1);
        if (q_l.size() != 0) check("lsb_down_data", l_dd, q_l[0]);
        check("msb_up_ready", m_up_ready, q_m.size() == 0);
        check("msb_down_valid", m_dv, q_m.size() != 0);
        check("msb_down_last", m_dl, q_m.size() == 1);
        if (q_m.size() != 0) check("msb_down_data", m_dd, q_m[0]);
    end

    // Present a word for one cycle; caller must be in an IDLE cycle
    task automatic send(input logic [W-1:0] w);
        up_valid = 1'b1;
        up_data  = w;
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        check("rst_up_ready", l_up_ready, 1);
        check("rst_down_valid", l_dv, 0);
        check("rst_down_data", l_dd, 0);
        check("rst_down_last", l_dl, 0);
        rst = 1'b0;
        down_ready = 1'b1;
        @(negedge clk);

        // Full-rate stream of 8'hC1 in both bit orders
        send(8'hC1);
        for (int i = 0; i < 8; i++) begin
            check("c1_lsb_bit", l_dd, exp_c1_l[i]);
            check("c1_msb_bit", m_dd, exp_c1_m[i]);
            check("c1_lsb_last", l_dl, i == 7);
            check("c1_msb_last", m_dl, i == 7);
            @(negedge clk);
        end
        check("c1_up_ready_ret", l_up_ready, 1);
        check("c1_valid_drop", l_dv, 0);

        // Backpressure for three cycles on bit 2
        send(8'hC1);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (!l_dv) break;
            cnt++;
            if (c >= 2 && c <= 5) check("bp_hold_bit", l_dd, 0);
            down_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
        end
        down_ready = 1'b1;
        check("bp_valid_cycles", cnt, 11);

        // Busy ignore: 8'hFF offered throughout the 8'hC1 stream
        up_valid = 1'b1;
        up_data  = 8'hC1;
        @(negedge clk);
        up_data = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            check("busy_up_ready", l_up_ready, 0);
            check("busy_lsb_bit", l_dd, exp_c1_l[i]);
            @(negedge clk);
        end
        check("busy_idle_ready", l_up_ready, 1);
        @(negedge clk);
        up_valid = 1'b0;
        check("busy_ff_valid", l_dv, 1);
        check("busy_ff_bit", l_dd, 1);
        repeat (8) @(negedge clk);

        // Reset in the middle of a word, then a clean 8'h01
        send(8'hC1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_up_ready", l_up_ready, 1);
        check("arst_down_valid", l_dv, 0);
        check("arst_down_data", l_dd, 0);
        check("arst_down_last", l_dl, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", l_dv, 0);
        send(8'h01);
        for (int i = 0; i < 8; i++) begin
            check("w01_lsb_bit", l_dd, exp_01_l[i]);
            check("w01_msb_bit", m_dd, exp_01_m[i]);
            @(negedge clk);
        end
        check("w01_done_ready", l_up_ready, 1);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serializer_using_mux.md
# serializer_using_mux

Parallel-to-serial stage that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted beat on a 1-bit valid/ready stream. It is built on the team's 2:1 `mux` primitive: each shift-register bit is selected by a mux instance (load vs. shift). It feeds single-bit consumers such as mux-based gate stages downstream.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH ≥ 2.
- `MSB_FIRST`, default 0: 0 emits bit 0 first; 1 emits bit WIDTH-1 first.

Ports:
- `clk`  input  1  the single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `up_valid`  input  1  upstream word is valid.
- `up_data`  input  WIDTH  upstream word.
- `up_ready`  output  1  block can accept a word.
- `down_valid`  output  1  `down_data` holds a valid bit.
- `down_data`  output  1  current serial bit.
- `down_last`  output  1  current bit is the final bit of the word.
- `down_ready`  input  1  downstream accepts the current bit.

## Operation
- Two states: IDLE and SHIFT.
- Registers:
  - `shreg`, WIDTH bits.
  - `cnt`, $clog2(WIDTH) bits.
  - `state`.
- IDLE:
  - `up_ready`=1, `down_valid`=0.
  - On `up_valid`&&`up_ready`: `shreg` ← `up_data`, `cnt` ← 0, state → SHIFT.
- SHIFT:
  - `up_ready`=0, `down_valid`=1.
  - `down_data` = `shreg[0]` when MSB_FIRST=0, `shreg[WIDTH-1]` when MSB_FIRST=1.
  - `down_last` = (`cnt`==WIDTH-1).
- Beat transfer happens when `down_valid`&&`down_ready`:
  - If the beat is not last: `shreg` shifts toward the output end, filling with 0, and `cnt` increments.
  - If the beat is last: state → IDLE. `shreg` and `cnt` keep don't-care values, but they must not produce spurious `down_valid`.
- Backpressure: while `down_valid`&&!`down_ready`, `down_data`, `down_last` and all state are held unchanged.
- `up_valid` asserted during SHIFT is ignored; `up_data` is not sampled.
- Per-bit next value of `shreg` is produced by a `mux` instance:
  - d0 = shift source (neighbour bit, or 0 at the fill end).
  - d1 = `up_data` bit.
  - sel = load.
  - The hold case is a clock-enable, not a mux input.
- `cnt` wraps never: it is compared to WIDTH-1 and cleared on load.

## Timing
- Reset values (asynchronous, take effect immediately on `rst` high):
  - state = IDLE, `shreg`=0, `cnt`=0.
  - Hence `up_ready`=1, `down_valid`=0, `down_data`=0, `down_last`=0.
- All outputs are decoded from registers only. There is no combinational path from `up_valid` or `down_ready` to any output.
- Latency: word accepted on edge N → first bit valid after edge N, i.e. in cycle N+1.
- With `down_ready` held at 1: bits occupy cycles N+1 … N+WIDTH; `up_ready` returns in cycle N+WIDTH+1.
- Throughput is one word per WIDTH+1 cycles at full downstream rate.
- Reset mid-word: the word is discarded. The next cycle after `rst` deasserts shows the reset values; no partial continuation.
- Simultaneous last-beat transfer and `up_valid`: the new word is not accepted in that cycle (`up_ready`=0). It is accepted in the following IDLE cycle.

## Structure
- Reuse the existing `mux` module as the only sub-module, with WIDTH instances created by a generate loop.
- A shared package `serializer_pkg` holds:
  - the state enum `serializer_state_t` {IDLE, SHIFT};
  - a `CNT_W(WIDTH)` helper equal to $clog2(WIDTH).
- Everything else stays local to the module.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `up_ready`=1, `down_valid`=0, `down_data`=0, `down_last`=0 immediately.
- WIDTH=8, MSB_FIRST=0, send 8'hC1, `down_ready`=1 → `down_data` 1,0,0,0,0,0,1,1 in cycles 1–8; `down_last` only in cycle 8; `up_ready`=1 in cycle 9.
- MSB_FIRST=1, send 8'hC1 → bits 1,1,0,0,0,0,0,1; `down_last` on the 8th bit.
- Backpressure: send 8'hC1, drop `down_ready` for 3 cycles on bit 2 → bit 2 (=0) is held stable and `down_valid` stays 1; sequence resumes unchanged; total 11 cycles of `down_valid`.
- Busy ignore: during SHIFT present `up_valid`=1 with 8'hFF → `up_ready`=0, stream still 8'hC1. 8'hFF is accepted in the first IDLE cycle after the last beat.
- Reset mid-word: assert `rst` after bit 3 of 8'hC1 → stream stops; after release, send 8'h01 → full 1,0,0,0,0,0,0,0 with no residue from 8'hC1.
